// File: rtl/wb_cp0_commit_stage.sv
// Writeback/commit stage with integrated CP0 register file.
// Commits GPR writes, exceptions and ERET; owns the Count/Compare timer.
module wb_cp0_commit_stage #(
   parameter int          NUM_HW_INT = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] EX_ENTRY   = 32'hBFC00380
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  ws_allowin,
   input  logic                  ms_to_ws_valid,
   input  logic [31:0]           ms_pc,
   input  logic [4:0]            ms_dest,
   input  logic [3:0]            ms_gr_strb,
   input  logic [31:0]           ms_result,
   input  logic                  ms_ex,
   input  logic                  ms_bd,
   input  logic [4:0]            ms_excode,
   input  logic [31:0]           ms_badvaddr,
   input  logic                  ms_eret,
   input  logic                  ms_mfc0,
   input  logic                  ms_mtc0,
   input  logic [7:0]            ms_cp0_addr,
   input  logic [NUM_HW_INT-1:0] ext_int_in,
   output logic [3:0]            rf_we,
   output logic [4:0]            rf_waddr,
   output logic [31:0]           rf_wdata,
   output logic [4:0]            ws_dest,
   output logic                  ws_mfc0,
   output logic                  ws_flush,
   output logic [31:0]           ws_flush_pc,
   output logic                  int_pending,
   output logic [31:0]           debug_wb_pc,
   output logic [3:0]            debug_wb_rf_wen,
   output logic [4:0]            debug_wb_rf_wnum,
   output logic [31:0]           debug_wb_rf_wdata
);

   localparam logic [7:0] A_BADV = 8'h40;
   localparam logic [7:0] A_CNT  = 8'h48;
   localparam logic [7:0] A_CMP  = 8'h58;
   localparam logic [7:0] A_ST   = 8'h60;
   localparam logic [7:0] A_CA   = 8'h68;
   localparam logic [7:0] A_EPC  = 8'h70;

   localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(COUNT_DIV - 1);

   logic        r_valid;
   logic [31:0] r_ms_pc;
   logic [4:0]  r_ms_dest;
   logic [3:0]  r_ms_strb;
   logic [31:0] r_ms_result;
   logic        r_ms_ex;
   logic        r_ms_bd;
   logic [4:0]  r_ms_excode;
   logic [31:0] r_ms_badv;
   logic        r_ms_eret;
   logic        r_ms_mfc0;
   logic        r_ms_mtc0;
   logic [7:0]  r_ms_addr;

   logic [7:0]  r_c0_im;
   logic        r_c0_exl;
   logic        r_c0_ie;
   logic        r_c0_bd;
   logic        r_c0_ti;
   logic [1:0]  r_c0_ip_sw;
   logic [4:0]  r_c0_excode;
   logic [31:0] r_c0_epc;
   logic [31:0] r_c0_badv;
   logic [31:0] r_c0_count;
   logic [31:0] r_c0_compare;
   logic [DW-1:0] r_div;
   logic [5:0]  r_hw;

   logic        r_flush;
   logic [31:0] r_flush_pc;

   logic        w_ready_go;
   logic        w_ex;
   logic        w_eret;
   logic        w_mtc0;
   logic        w_wr_count;
   logic        w_wr_compare;
   logic        w_div_wrap;
   logic        w_count_upd;
   logic [31:0] w_count_nxt;
   logic [5:0]  w_hw_ext;
   logic [7:0]  w_ip;
   logic [31:0] w_status;
   logic [31:0] w_cause;
   logic [31:0] w_cp0_rdata;

   assign w_ready_go   = 1'b1;
   assign ws_allowin   = !r_valid | w_ready_go;
   assign w_ex         = r_valid & r_ms_ex;
   assign w_eret       = r_valid & r_ms_eret & !r_ms_ex;
   assign w_mtc0       = r_valid & r_ms_mtc0 & !r_ms_ex;
   assign w_wr_count   = w_mtc0 & (r_ms_addr == A_CNT);
   assign w_wr_compare = w_mtc0 & (r_ms_addr == A_CMP);
   assign w_div_wrap   = (r_div == DIV_MAX);
   assign w_count_upd  = w_wr_count | w_div_wrap;
   assign w_count_nxt  = w_wr_count ? r_ms_result : r_c0_count + 32'd1;
   assign w_hw_ext     = 6'(ext_int_in);

   assign w_ip     = {r_c0_ti | r_hw[5], r_hw[4:0], r_c0_ip_sw};
   assign w_status = {9'd0, 1'b1, 6'd0, r_c0_im, 6'd0, r_c0_exl, r_c0_ie};
   assign w_cause  = {r_c0_bd, r_c0_ti, 14'd0, w_ip, 1'b0, r_c0_excode, 2'b00};

   // Pipeline latch: accept the MEM-stage payload whenever allowed
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid     <= 1'b0;
         r_ms_pc     <= 32'd0;
         r_ms_dest   <= 5'd0;
         r_ms_strb   <= 4'd0;
         r_ms_result <= 32'd0;
         r_ms_ex     <= 1'b0;
         r_ms_bd     <= 1'b0;
         r_ms_excode <= 5'd0;
         r_ms_badv   <= 32'd0;
         r_ms_eret   <= 1'b0;
         r_ms_mfc0   <= 1'b0;
         r_ms_mtc0   <= 1'b0;
         r_ms_addr   <= 8'd0;
      end else if (ws_allowin) begin
         r_valid <= ms_to_ws_valid;
         if (ms_to_ws_valid) begin
            r_ms_pc     <= ms_pc;
            r_ms_dest   <= ms_dest;
            r_ms_strb   <= ms_gr_strb;
            r_ms_result <= ms_result;
            r_ms_ex     <= ms_ex;
            r_ms_bd     <= ms_bd;
            r_ms_excode <= ms_excode;
            r_ms_badv   <= ms_badvaddr;
            r_ms_eret   <= ms_eret;
            r_ms_mfc0   <= ms_mfc0;
            r_ms_mtc0   <= ms_mtc0;
            r_ms_addr   <= ms_cp0_addr;
         end
      end
   end

   // CP0 Status/Cause/EPC/BadVAddr: exception, then eret, then mtc0
   always_ff @(posedge clk) begin
      if (reset) begin
         r_c0_im     <= 8'd0;
         r_c0_exl    <= 1'b0;
         r_c0_ie     <= 1'b0;
         r_c0_bd     <= 1'b0;
         r_c0_ip_sw  <= 2'd0;
         r_c0_excode <= 5'd0;
         r_c0_epc    <= 32'd0;
         r_c0_badv   <= 32'd0;
      end else if (w_ex) begin
         if (!r_c0_exl) begin
            r_c0_epc <= r_ms_bd ? r_ms_pc - 32'd4 : r_ms_pc;
            r_c0_bd  <= r_ms_bd;
         end
         r_c0_exl    <= 1'b1;
         r_c0_excode <= r_ms_excode;
         if (r_ms_excode == 5'd4 || r_ms_excode == 5'd5)
            r_c0_badv <= r_ms_badv;
      end else if (w_eret) begin
         r_c0_exl <= 1'b0;
      end else if (w_mtc0) begin
         case (r_ms_addr)
            A_ST: begin
               r_c0_im  <= r_ms_result[15:8];
               r_c0_exl <= r_ms_result[1];
               r_c0_ie  <= r_ms_result[0];
            end
            A_CA:    r_c0_ip_sw <= r_ms_result[9:8];
            A_EPC:   r_c0_epc   <= r_ms_result;
            default: ;
         endcase
      end
   end

   // Count/Compare timer with prescaler and sticky timer interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         r_c0_count   <= 32'd0;
         r_c0_compare <= 32'd0;
         r_div        <= '0;
         r_c0_ti      <= 1'b0;
      end else begin
         if (w_count_upd) begin
            r_c0_count <= w_count_nxt;
            r_div      <= '0;
         end else begin
            r_div <= r_div + DW'(1);
         end
         if (w_wr_compare) begin
            r_c0_compare <= r_ms_result;
            r_c0_ti      <= 1'b0;
         end else if (w_count_upd && w_count_nxt == r_c0_compare) begin
            r_c0_ti <= 1'b1;
         end
      end
   end

   // Sample hardware interrupt lines; unused lines read zero
   always_ff @(posedge clk) begin
      if (reset) r_hw <= 6'd0;
      else       r_hw <= w_hw_ext;
   end

   // Registered one-cycle flush/redirect after exception or eret commit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flush    <= 1'b0;
         r_flush_pc <= 32'd0;
      end else begin
         r_flush    <= w_ex | w_eret;
         r_flush_pc <= w_ex ? EX_ENTRY : (w_eret ? r_c0_epc : 32'd0);
      end
   end

   // CP0 read mux for mfc0
   always_comb begin
      w_cp0_rdata = 32'd0;
      case (r_ms_addr)
         A_BADV:  w_cp0_rdata = r_c0_badv;
         A_CNT:   w_cp0_rdata = r_c0_count;
         A_CMP:   w_cp0_rdata = r_c0_compare;
         A_ST:    w_cp0_rdata = w_status;
         A_CA:    w_cp0_rdata = w_cause;
         A_EPC:   w_cp0_rdata = r_c0_epc;
         default: w_cp0_rdata = 32'd0;
      endcase
   end

   assign rf_we       = (r_valid & !r_ms_ex & !reset) ? r_ms_strb : 4'd0;
   assign rf_waddr    = r_valid ? r_ms_dest : 5'd0;
   assign rf_wdata    = !r_valid ? 32'd0 :
                        (r_ms_mfc0 ? w_cp0_rdata : r_ms_result);
   assign ws_dest     = r_valid ? r_ms_dest : 5'd0;
   assign ws_mfc0     = r_valid & r_ms_mfc0;
   assign ws_flush    = r_flush;
   assign ws_flush_pc = r_flush_pc;
   assign int_pending = r_c0_ie & !r_c0_exl & |(w_ip & r_c0_im);

   assign debug_wb_pc       = r_valid ? r_ms_pc : 32'd0;
   assign debug_wb_rf_wen   = rf_we;
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_cp0_commit_stage.sv
// Directed bench for wb_cp0_commit_stage.
// Vector table for GPR/CP0 access plus exception/timer/interrupt sequences.
module tb_wb_cp0_commit_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ws_allowin;
   logic        ms_to_ws_valid;
   logic [31:0] ms_pc;
   logic [4:0]  ms_dest;
   logic [3:0]  ms_gr_strb;
   logic [31:0] ms_result;
   logic        ms_ex, ms_bd;
   logic [4:0]  ms_excode;
   logic [31:0] ms_badvaddr;
   logic        ms_eret, ms_mfc0, ms_mtc0;
   logic [7:0]  ms_cp0_addr;
   logic [5:0]  ext_int_in;
   logic [3:0]  rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  ws_dest;
   logic        ws_mfc0;
   logic        ws_flush;
   logic [31:0] ws_flush_pc;
   logic        int_pending;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   int n_chk = 0;
   int n_fail = 0;

   localparam logic [7:0] BV = 8'h40, CNT = 8'h48, CMP = 8'h58;
   localparam logic [7:0] ST = 8'h60, CA = 8'h68, EPC = 8'h70;

   wb_cp0_commit_stage dut (
      .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
      .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
      .ms_dest(ms_dest), .ms_gr_strb(ms_gr_strb),
      .ms_result(ms_result), .ms_ex(ms_ex), .ms_bd(ms_bd),
      .ms_excode(ms_excode), .ms_badvaddr(ms_badvaddr),
      .ms_eret(ms_eret), .ms_mfc0(ms_mfc0), .ms_mtc0(ms_mtc0),
      .ms_cp0_addr(ms_cp0_addr), .ext_int_in(ext_int_in),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .ws_dest(ws_dest), .ws_mfc0(ws_mfc0), .ws_flush(ws_flush),
      .ws_flush_pc(ws_flush_pc), .int_pending(int_pending),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum),
      .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  dest;
      logic [3:0]  strb;
      logic [31:0] result;
      logic        mfc0;
      logic        mtc0;
      logic [7:0]  addr;
      logic [3:0]  e_we;
      logic [31:0] e_wdata;
   } vec_t;

   vec_t v [21];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [4:0] dest,
                        input logic [3:0] strb, input logic [31:0] res,
                        input logic mf, input logic mt,
                        input logic [7:0] addr, input logic ex,
                        input logic bd, input logic [4:0] code,
                        input logic [31:0] bv, input logic er);
      ms_pc = pc; ms_dest = dest; ms_gr_strb = strb;
      ms_result = res; ms_mfc0 = mf; ms_mtc0 = mt;
      ms_cp0_addr = addr; ms_ex = ex; ms_bd = bd;
      ms_excode = code; ms_badvaddr = bv; ms_eret = er;
      ms_to_ws_valid = 1'b1;
      @(posedge clk);
      #1;
      ms_to_ws_valid = 1'b0;
      ms_ex = 1'b0; ms_eret = 1'b0;
      ms_mfc0 = 1'b0; ms_mtc0 = 1'b0;
   endtask

   task automatic mtc0(input logic [7:0] addr, input logic [31:0] d);
      issue(32'h100, 5'd0, 4'h0, d, 1'b0, 1'b1, addr,
            1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   task automatic rd(input string name, input logic [7:0] addr,
                     input logic [31:0] exp);
      issue(32'h200, 5'd2, 4'hF, 32'd0, 1'b1, 1'b0, addr,
            1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      chk(name, rf_wdata, exp);
   endtask

   task automatic exc(input logic [31:0] pc, input logic bd,
                      input logic [4:0] code, input logic [31:0] bv,
                      input logic er);
      issue(pc, 5'd4, 4'hF, 32'h77, 1'b0, 1'b0, 8'd0,
            1'b1, bd, code, bv, er);
   endtask

   initial begin
      v[0]  = '{5'd2, 4'hF, 32'd0,        1'b1, 1'b0, ST,   4'hF, 32'h0040_0000};
      v[1]  = '{5'd3, 4'hF, 32'h1234,     1'b0, 1'b0, 8'd0, 4'hF, 32'h1234};
      v[2]  = '{5'd7, 4'h1, 32'hAB,       1'b0, 1'b0, 8'd0, 4'h1, 32'hAB};
      v[3]  = '{5'd0, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b1, ST,   4'h0, 32'hFFFFFFFF};
      v[4]  = '{5'd2, 4'hF, 32'd0,        1'b1, 1'b0, ST,   4'hF, 32'h0040_FF03};
      v[5]  = '{5'd0, 4'h0, 32'd0,        1'b0, 1'b1, ST,   4'h0, 32'd0};
      v[6]  = '{5'd2, 4'hF, 32'd0,        1'b1, 1'b0, ST,   4'hF, 32'h0040_0000};
      v[7]  = '{5'd0, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b1, CA,   4'h0, 32'hFFFFFFFF};
      v[8]  = '{5'd2, 4'hF, 32'd0,        1'b1, 1'b0, CA,   4'hF, 32'h0000_0300};
      v[9]  = '{5'd0, 4'h0, 32'd0,        1'b0, 1'b1, CA,   4'h0, 32'd0};
      v[10] = '{5'd2, 4'hF, 32'd0,        1'b1, 1'b0, CA,   4'hF, 32'd0};
      v[11] = '{5'd0, 4'h0, 32'h12345678, 1'b0, 1'b1, EPC,  4'h0, 32'h12345678};
      v[12] = '{5'd5, 4'hF, 32'd0,        1'b1, 1'b0, EPC,  4'hF, 32'h12345678};
      v[13] = '{5'd0, 4'h0, 32'hDEAD,     1'b0, 1'b1, BV,   4'h0, 32'hDEAD};
      v[14] = '{5'd6, 4'hF, 32'd0,        1'b1, 1'b0, BV,   4'hF, 32'd0};
      v[15] = '{5'd2, 4'hF, 32'd0,        1'b1, 1'b0, 8'h78, 4'hF, 32'd0};
      v[16] = '{5'd2, 4'hF, 32'd0,        1'b1, 1'b0, 8'h61, 4'hF, 32'd0};
      v[17] = '{5'd0, 4'h0, 32'h1000,     1'b0, 1'b1, CMP,  4'h0, 32'h1000};
      v[18] = '{5'd8, 4'hF, 32'd0,        1'b1, 1'b0, CMP,  4'hF, 32'h1000};
      v[19] = '{5'd0, 4'h0, 32'd100,      1'b0, 1'b1, CNT,  4'h0, 32'd100};
      v[20] = '{5'd9, 4'hF, 32'd0,        1'b1, 1'b0, CNT,  4'hF, 32'd100};

      reset = 1'b1;
      ms_to_ws_valid = 1'b0; ms_pc = '0; ms_dest = '0;
      ms_gr_strb = '0; ms_result = '0; ms_ex = 1'b0;
      ms_bd = 1'b0; ms_excode = '0; ms_badvaddr = '0;
      ms_eret = 1'b0; ms_mfc0 = 1'b0; ms_mtc0 = 1'b0;
      ms_cp0_addr = '0; ext_int_in = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_flush", 32'(ws_flush), 32'd0);
      chk("rst_int", 32'(int_pending), 32'd0);
      chk("rst_allowin", 32'(ws_allowin), 32'd1);
      chk("rst_dbg_pc", debug_wb_pc, 32'd0);
      chk("rst_dest", 32'(ws_dest), 32'd0);

      for (int i = 0; i < 21; i++) begin
         issue(32'h1000 + 32'(i) * 4, v[i].dest, v[i].strb,
               v[i].result, v[i].mfc0, v[i].mtc0, v[i].addr,
               1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
         chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(v[i].e_we));
         chk($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(v[i].dest));
         chk($sformatf("v%0d_wdata", i), rf_wdata, v[i].e_wdata);
         chk($sformatf("v%0d_wsdest", i), 32'(ws_dest), 32'(v[i].dest));
         chk($sformatf("v%0d_wsmfc0", i), 32'(ws_mfc0), 32'(v[i].mfc0));
         chk($sformatf("v%0d_dbgpc", i), debug_wb_pc,
             32'h1000 + 32'(i) * 4);
      end

      tick();
      chk("idle_we", 32'(rf_we), 32'd0);
      chk("idle_dbgpc", debug_wb_pc, 32'd0);

      mtc0(CNT, 32'd200);
      repeat (5) @(posedge clk);
      #1;
      rd("count_div", CNT, 32'd202);

      exc(32'h8000_1004, 1'b1, 5'd4, 32'h5, 1'b0);
      chk("ex1_we", 32'(rf_we), 32'd0);
      chk("ex1_noflush_yet", 32'(ws_flush), 32'd0);
      tick();
      chk("ex1_flush", 32'(ws_flush), 32'd1);
      chk("ex1_flush_pc", ws_flush_pc, 32'hBFC0_0380);
      tick();
      chk("ex1_flush_end", 32'(ws_flush), 32'd0);
      rd("ex1_epc", EPC, 32'h8000_1000);
      rd("ex1_cause", CA, 32'h8000_0010);
      rd("ex1_badv", BV, 32'h5);
      rd("ex1_status", ST, 32'h0040_0002);

      exc(32'h8000_2000, 1'b0, 5'd5, 32'h99, 1'b0);
      tick();
      chk("ex2_flush", 32'(ws_flush), 32'd1);
      rd("ex2_epc", EPC, 32'h8000_1000);
      rd("ex2_cause", CA, 32'h8000_0014);
      rd("ex2_badv", BV, 32'h99);

      exc(32'h8000_3000, 1'b0, 5'd10, 32'h777, 1'b1);
      tick();
      chk("ex3_flush_pc", ws_flush_pc, 32'hBFC0_0380);
      rd("ex3_badv", BV, 32'h99);
      rd("ex3_status", ST, 32'h0040_0002);

      issue(32'h8000_4000, 5'd0, 4'h0, 32'd0, 1'b0, 1'b0, 8'd0,
            1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      tick();
      chk("eret_flush", 32'(ws_flush), 32'd1);
      chk("eret_flush_pc", ws_flush_pc, 32'h8000_1000);
      rd("eret_status", ST, 32'h0040_0000);
      chk("eret_flush_end", 32'(ws_flush), 32'd0);

      mtc0(ST, 32'h0000_8001);
      mtc0(CMP, 32'd10);
      mtc0(CNT, 32'd8);
      tick();
      chk("ti_c8", 32'(int_pending), 32'd0);
      tick(); tick(); tick();
      chk("ti_c9", 32'(int_pending), 32'd0);
      tick();
      chk("ti_c10", 32'(int_pending), 32'd1);
      rd("ti_cause", CA, 32'hC000_8028);
      mtc0(CMP, 32'd20);
      tick();
      chk("ti_clear", 32'(int_pending), 32'd0);
      rd("ti_cause_clr", CA, 32'h8000_0028);
      mtc0(CMP, 32'hFFFF_0000);

      mtc0(ST, 32'h0000_0401);
      ext_int_in = 6'b000001;
      tick(); tick();
      chk("hw0_int", 32'(int_pending), 32'd1);
      rd("hw0_cause", CA, 32'h8000_0428);
      mtc0(ST, 32'h0000_0403);
      tick();
      chk("hw0_exl_mask", 32'(int_pending), 32'd0);
      ext_int_in = 6'b100000;
      mtc0(ST, 32'h0000_8001);
      tick(); tick();
      chk("hw5_ip7", 32'(int_pending), 32'd1);
      ext_int_in = 6'd0;
      tick(); tick();
      chk("hw_drop", 32'(int_pending), 32'd0);

      issue(32'h3000, 5'd9, 4'hF, 32'h55, 1'b0, 1'b0, 8'd0,
            1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("rstmid_pre", 32'(rf_we), 32'hF);
      reset = 1'b1;
      #1;
      chk("rstmid_we", 32'(rf_we), 32'd0);
      tick();
      reset = 1'b0;
      chk("rstmid_post_we", 32'(rf_we), 32'd0);
      chk("rstmid_int", 32'(int_pending), 32'd0);
      rd("rstmid_status", ST, 32'h0040_0000);
      rd("rstmid_epc", EPC, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
